// File: rtl/instruction_sequencer_if.sv
// Host-side bus for instruction_sequencer: program load, start/stall control,
// and the issued instruction plus status flags back to the host.
interface instruction_sequencer_if #(
    parameter int PA    = 8,
    parameter int INS_W = 26
);
    logic             progWrite;
    logic [PA-1:0]    progAddr;
    logic [INS_W-1:0] progData;
    logic             start;
    logic [PA-1:0]    startAddr;
    logic             stall;
    logic [INS_W-1:0] instruction;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output progWrite, progAddr, progData,
        output start, startAddr, stall,
        input  instruction, busy, done, error
    );

    modport slave (
        input  progWrite, progAddr, progData,
        input  start, startAddr, stall,
        output instruction, busy, done, error
    );
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: program store and sequencer feeding MasterController.
// Ports: CLK, RST (sync, active-high), bus (slave modport: progWrite/progAddr/
// progData load, start/startAddr/stall control, instruction/busy/done/error).
// Optional: define ISEQ_PERF_COUNT_EN to add output issuedCount[31:0].
module instruction_sequencer #(
    parameter int depth  = 2,
    parameter int W      = 16,
    parameter int INS_W  = 4 + 2 + 2 * ((depth > 2) ? depth : 2)
                         + (((2 ** depth) > W) ? (2 ** depth) : W),
    parameter int PA     = 8,
    parameter int LSTACK = 2
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef ISEQ_PERF_COUNT_EN
    output logic [31:0] issuedCount,
`endif
    instruction_sequencer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_NOP  = 4'b0101;
    localparam logic [3:0] OP_LS   = 4'b1111;
    localparam logic [3:0] OP_LE   = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b0111;

    localparam logic [INS_W-1:0] NOP = {OP_NOP, {(INS_W-4){1'b0}}};

    localparam int SPW = $clog2(LSTACK + 1);
    localparam int CW  = 16;

    logic [INS_W-1:0] prog [2**PA];

    logic [1:0]       state;
    logic [PA-1:0]    pc;
    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   top;
    logic [PA-1:0]    stkAddr [2**SPW];
    logic [CW-1:0]    stkCnt  [2**SPW];

    logic [INS_W-1:0] w;
    logic [3:0]       op;
    logic [CW-1:0]    n;
    logic             running;

    logic doPush;
    logic doDec;
    logic doPop;
    logic fault;
    logic halt;
    logic issue;

    assign w       = prog[pc];
    assign op      = w[INS_W-1 -: 4];
    assign top     = sp - SPW'(1);
    assign n       = (w[CW-1:0] == '0) ? CW'(1) : w[CW-1:0];
    assign running = (state == RUN);

    assign bus.busy = running;

    // Writes are locked out while running so the program cannot change
    // under the sequencer.
    always_ff @(posedge CLK) begin
        if (bus.progWrite && !running) begin
            prog[bus.progAddr] <= bus.progData;
        end
    end

    always_comb begin
        doPush = 1'b0;
        doDec  = 1'b0;
        doPop  = 1'b0;
        fault  = 1'b0;
        halt   = 1'b0;
        issue  = 1'b0;
        if (running && !bus.stall) begin
            unique case (op)
                OP_LS: begin
                    if (sp == SPW'(LSTACK)) fault  = 1'b1;
                    else                    doPush = 1'b1;
                end
                OP_LE: begin
                    if (sp == '0)                fault = 1'b1;
                    else if (stkCnt[top] != '0)  doDec = 1'b1;
                    else                         doPop = 1'b1;
                end
                OP_HALT: halt  = 1'b1;
                default: issue = 1'b1;
            endcase
        end
    end

    // Each entry holds the loop body address and the number of
    // jump-backs still owed (n-1 at push).
    always_ff @(posedge CLK) begin
        if (doPush) begin
            stkAddr[sp] <= pc + PA'(1);
            stkCnt[sp]  <= n - CW'(1);
        end else if (doDec) begin
            stkCnt[top] <= stkCnt[top] - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            pc              <= '0;
            sp              <= '0;
            bus.instruction <= NOP;
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
        end else begin
            bus.instruction <= NOP;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state     <= RUN;
                        pc        <= bus.startAddr;
                        sp        <= '0;
                        bus.done  <= 1'b0;
                        bus.error <= 1'b0;
                    end
                end
                RUN: begin
                    if (fault || halt) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end
                    if (fault) bus.error <= 1'b1;
                    if (issue) bus.instruction <= w;
                    if (issue || doPush || doPop) pc <= pc + PA'(1);
                    if (doDec) pc <= stkAddr[top];
                    if (doPush) sp <= sp + SPW'(1);
                    if (doPop) sp <= sp - SPW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ISEQ_PERF_COUNT_EN
    logic accept;
    assign accept = bus.start && !running;

    always_ff @(posedge CLK) begin
        if (RST || accept) begin
            issuedCount <= '0;
        end else if (issue && w != NOP && issuedCount != 32'hFFFF_FFFF) begin
            issuedCount <= issuedCount + 32'd1;
        end
    end
`else
    // No issue counter in this build.
`endif
endmodule
